// File: rtl/cache_arb_pkg.sv
// Shared types and defaults for the cache request arbiter.
package cache_arb_pkg;

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} arb_state_e;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_TIMEOUT = 255;

  function automatic int cnt_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/cache_req_arbiter_rr_pick.sv
// Combinational round-robin pick: first set request scanning upward from ptr+1.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IW      = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IW-1:0]      idx,
  output logic               vld
);

  logic [IW-1:0] c;

  always_comb begin
    gnt = '0;
    idx = '0;
    vld = 1'b0;
    c   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      c = IW'((int'(ptr) + k) % NUM_REQ);
      if (!vld && req[c]) begin
        vld    = 1'b1;
        gnt[c] = 1'b1;
        idx    = c;
      end
    end
  end

endmodule

// File: rtl/cache_req_arbiter.sv
// Round-robin arbiter sharing one cache_controller ld/st/addr port between
// NUM_REQ requesters, one outstanding access at a time, with a watchdog.
module cache_req_arbiter
  import cache_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_st,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        req_grant,
  output logic [NUM_REQ-1:0]        req_done,
  output logic                      req_hit,
  output logic                      timeout_err,
  output logic                      busy,
  output logic                      ld,
  output logic                      st,
  output logic [ADDR_W-1:0]         addr,
  input  logic                      hit,
  input  logic                      miss,
  input  logic                      load_ready
);

  localparam int IW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = cnt_width(TIMEOUT);

  arb_state_e state, state_nx;

  logic [NUM_REQ-1:0][ADDR_W-1:0] addr_arr;
  logic [NUM_REQ-1:0] pick_oh;
  logic [IW-1:0]      pick_idx;
  logic               pick_vld;

  logic [IW-1:0]      rr_ptr, idx_q, rr_ptr_nx, idx_nx;
  logic               miss_seen, miss_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;

  logic [NUM_REQ-1:0] grant_nx, done_nx;
  logic               hit_nx, to_nx, ld_nx, st_nx;
  logic [ADDR_W-1:0]  addr_nx;

  assign addr_arr = req_addr;

  rr_pick #(.NUM_REQ(NUM_REQ), .IW(IW)) u_pick (
    .req (req_valid),
    .ptr (rr_ptr),
    .gnt (pick_oh),
    .idx (pick_idx),
    .vld (pick_vld)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    rr_ptr_nx = rr_ptr;
    idx_nx    = idx_q;
    miss_nx   = miss_seen;
    cnt_nx    = cnt;
    grant_nx  = '0;
    done_nx   = '0;
    hit_nx    = 1'b0;
    to_nx     = 1'b0;
    ld_nx     = ld;
    st_nx     = st;
    addr_nx   = addr;
    unique case (state)
      IDLE: if (pick_vld) begin
        state_nx  = ACTIVE;
        rr_ptr_nx = pick_idx;
        idx_nx    = pick_idx;
        grant_nx  = pick_oh;
        ld_nx     = ~req_st[pick_idx];
        st_nx     = req_st[pick_idx];
        addr_nx   = addr_arr[pick_idx];
        miss_nx   = 1'b0;
        cnt_nx    = '0;
      end
      ACTIVE: begin
        // hit in the same cycle as miss completes as a hit
        if (hit || load_ready || cnt == CNT_W'(TIMEOUT - 1)) begin
          state_nx       = DONE;
          done_nx[idx_q] = 1'b1;
          hit_nx         = hit & ~miss_seen;
          to_nx          = ~(hit | load_ready);
          ld_nx          = 1'b0;
          st_nx          = 1'b0;
          addr_nx        = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
          if (miss) miss_nx = 1'b1;
        end
      end
      DONE: begin
        state_nx = IDLE;
        miss_nx  = 1'b0;
        cnt_nx   = '0;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr      <= IW'(NUM_REQ - 1);
      idx_q       <= '0;
      miss_seen   <= 1'b0;
      cnt         <= '0;
      req_grant   <= '0;
      req_done    <= '0;
      req_hit     <= 1'b0;
      timeout_err <= 1'b0;
      busy        <= 1'b0;
      ld          <= 1'b0;
      st          <= 1'b0;
      addr        <= '0;
    end else begin
      rr_ptr      <= rr_ptr_nx;
      idx_q       <= idx_nx;
      miss_seen   <= miss_nx;
      cnt         <= cnt_nx;
      req_grant   <= grant_nx;
      req_done    <= done_nx;
      req_hit     <= hit_nx;
      timeout_err <= to_nx;
      busy        <= (state_nx != IDLE);
      ld          <= ld_nx;
      st          <= st_nx;
      addr        <= addr_nx;
    end
  end

endmodule

// File: doc/cache_req_arbiter.md
Name: cache_req_arbiter

Overview:
- Shares the single ld/st/addr port of the 2-way cache_controller between NUM_REQ requesters, for example the instruction fetch, data load/store and prefetch agents.
- Uses round-robin arbitration. Exactly one access is outstanding at a time.
- Holds the controller command until the access completes by hit or by load_ready after a miss, then returns a completion pulse to the winning requester.
- A watchdog releases the port if the controller never completes.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_W, 32, address width; must match cache_controller addr.
- TIMEOUT, 255, maximum cycles in ACTIVE before a forced release (1..65535).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request. Held until that requester's req_grant bit pulses.
- req_st  in  NUM_REQ  per-requester op: 1 = store, 0 = load.
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i occupies bits [i*ADDR_W +: ADDR_W].
- req_grant  out  NUM_REQ  one-hot, one-cycle pulse: request captured.
- req_done  out  NUM_REQ  one-hot, one-cycle pulse: access finished.
- req_hit  out  1  valid with req_done; 1 = completed as hit with no preceding miss.
- timeout_err  out  1  valid with req_done; 1 = watchdog release.
- busy  out  1  high in every state except IDLE.
- ld  out  1  to cache_controller ld.
- st  out  1  to cache_controller st.
- addr  out  ADDR_W  to cache_controller addr.
- hit  in  1  from cache_controller.
- miss  in  1  from cache_controller.
- load_ready  in  1  from cache_controller.

Behaviour:
- Reset:
  - State goes to IDLE.
  - All outputs are 0 (ld, st, addr, req_grant, req_done, req_hit, timeout_err, busy).
  - rr_ptr is set to NUM_REQ-1, so requester 0 has first priority.
  - The miss_seen flag and the timeout counter are cleared.
  - Reset in any state aborts the access immediately. No req_done is issued for the aborted access.
- All outputs are registered.
- States are IDLE, ACTIVE and DONE.
- IDLE:
  - If req_valid is nonzero in cycle T, select the winner: the first set bit scanning upward from rr_ptr+1 modulo NUM_REQ.
  - Capture the winner's index, req_st and req_addr.
  - Set rr_ptr to the winner index.
  - Go to ACTIVE at T+1.
- ACTIVE entry cycle (T+1):
  - req_grant[idx] pulses.
  - ld = ~st_cap and st = st_cap, with addr = addr_cap.
  - These command values hold unchanged for every ACTIVE cycle.
- In ACTIVE, each cycle:
  - Sample hit, miss and load_ready.
  - Completion is hit OR load_ready.
  - miss without completion sets miss_seen.
  - If hit and miss are both high in the same cycle, hit wins and miss_seen is not set.
  - Completion goes to DONE with hit_flag = hit & ~miss_seen.
  - Any other ACTIVE cycle increments the counter. When the counter reaches TIMEOUT-1 without completion, go to DONE with timeout flagged.
- DONE (one cycle):
  - ld = st = 0 and addr = 0.
  - req_done[idx] pulses.
  - req_hit = hit_flag, timeout_err = timeout flag (mutually exclusive).
  - Clear miss_seen and the counter.
  - Go to IDLE.
- Minimum latency: request at T, ld/st from T+1, hit sampled at T+1, req_done at T+2, IDLE at T+3, next command no earlier than T+4.
- There is always at least one command-free cycle between accesses.
- hit, miss and load_ready are ignored in IDLE and DONE.
- Requester rules:
  - req_valid of a non-granted requester remains pending and is never lost.
  - A granted requester must drop req_valid after its grant pulse. If it is still high on return to IDLE, it is treated as a new request.
- Fairness: with all requesters continuously valid, grants rotate 0,1,...,NUM_REQ-1,0,...

Decomposition:
- Package cache_arb_pkg holds:
  - the state enum arb_state_e {IDLE, ACTIVE, DONE};
  - default constants for NUM_REQ, ADDR_W and TIMEOUT;
  - a helper function computing the counter width, $clog2(TIMEOUT+1).
- Sub-module rr_pick, combinational:
  - inputs req vector and rr_ptr;
  - outputs a one-hot grant and its index;
  - valid output is 0 when the request vector is empty.
- cache_req_arbiter holds the FSM, the capture registers, the counter and the output registers.

Test Plan:
- Reset held 10 cycles with req_valid=4'b1111 → all outputs 0 throughout. After release, req_grant=4'b0001 two cycles later.
- Requester 2 load at 0x0000_1A40, controller hit at the first ACTIVE cycle:
  - ld=1 and addr=0x1A40 for exactly 1 cycle;
  - req_done=4'b0100 and req_hit=1 one cycle later;
  - st stays 0.
- Requester 1 store at 0xFFFF_FFFC: miss pulse, load_ready 6 cycles later →
  - st held for 7 cycles;
  - req_done=4'b0010, req_hit=0, timeout_err=0.
- All four requesters valid continuously, every access a hit → grant order 0,1,2,3,0. One grant every 3 cycles.
- TIMEOUT=8 with no controller response → ld held exactly 8 cycles, then req_done with timeout_err=1, then the next requester is served.
- hit and miss asserted in the same cycle → req_hit=1. Reset asserted mid-ACTIVE → ld drops the next cycle and no req_done occurs.
